tf_exp_gen: RTL and testbench



---
 rtl/tf_exp_gen.sv | 145 ++++++++++++++
 tb/tb_tf_exp_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tf_exp_gen.sv
// Twiddle-exponent sequencer for a 256-point radix-2 FFT: walks stage/group
// counters and issues four ROM exponents per cycle plus a ROM-aligned valid.
// Ports: CLK, RSTn (async low) | START, HOLD in | EXP0..3, EXP_VLD, TF_VLD,
//        STAGE, GRP, BUSY, DONE out (all registered).
// Build option: define TFGEN_DIT_EN for decimation-in-time exponent order.
module tf_exp_gen #(
   parameter int STAGES = 8
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       START,
   input  logic       HOLD,
   output logic [7:0] EXP0,
   output logic [7:0] EXP1,
   output logic [7:0] EXP2,
   output logic [7:0] EXP3,
   output logic       EXP_VLD,
   output logic       TF_VLD,
   output logic [2:0] STAGE,
   output logic [4:0] GRP,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam logic [2:0] LAST_S = 3'(STAGES - 1);

   state_t          r_state, w_state_nxt;
   logic [2:0]      r_s, w_s_nxt;
   logic [4:0]      r_g, w_g_nxt;
   logic            r_vld, w_vld_nxt;
   logic            r_iss, w_iss_nxt;
   logic            r_tf_vld;
   logic            r_done, w_done_nxt;
   logic [3:0][7:0] r_exp, w_lane;
   logic            w_last;
   logic            w_issued;

   function automatic logic [7:0] lane_exp(
      input logic [2:0] s,
      input logic [4:0] g,
      input logic [1:0] lane
   );
      logic [7:0] b, half, j;
      b = {1'b0, g, lane};
`ifdef TFGEN_DIT_EN
      half = 8'd1 << s;
      j    = b & (half - 8'd1);
      return j << (3'd7 - s);
`else
      half = 8'd128 >> s;
      j    = b & (half - 8'd1);
      return j << s;
`endif
   endfunction

   assign w_last   = (r_s == LAST_S) && (r_g == 5'd31);
   // Displayed group already had its EXP_VLD cycle (possibly before a HOLD).
   assign w_issued = r_vld | r_iss;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_state  <= S_IDLE;
         r_s      <= '0;
         r_g      <= '0;
         r_vld    <= 1'b0;
         r_iss    <= 1'b0;
         r_tf_vld <= 1'b0;
         r_done   <= 1'b0;
         r_exp    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_s      <= w_s_nxt;
         r_g      <= w_g_nxt;
         r_vld    <= w_vld_nxt;
         r_iss    <= w_iss_nxt;
         r_tf_vld <= r_vld;
         r_done   <= w_done_nxt;
         r_exp    <= (w_state_nxt == S_RUN) ? w_lane : '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (START) w_state_nxt = S_RUN;
         S_RUN:  if (r_vld && w_last) w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_s_nxt    = r_s;
      w_g_nxt    = r_g;
      w_vld_nxt  = 1'b0;
      w_iss_nxt  = r_iss;
      w_done_nxt = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_s_nxt   = '0;
            w_g_nxt   = '0;
            w_iss_nxt = 1'b0;
            if (START) w_vld_nxt = !HOLD;
         end
         S_RUN: begin
            if (r_vld && w_last) begin
               // Last group is issued; finish even if HOLD rises now.
               w_s_nxt    = '0;
               w_g_nxt    = '0;
               w_iss_nxt  = 1'b0;
               w_done_nxt = 1'b1;
            end else if (HOLD) begin
               w_iss_nxt = w_issued;
            end else if (w_issued) begin
               w_g_nxt   = r_g + 5'd1;
               w_s_nxt   = (r_g == 5'd31) ? r_s + 3'd1 : r_s;
               w_vld_nxt = 1'b1;
               w_iss_nxt = 1'b0;
            end else begin
               // Group shown during a stall but never issued: issue it now.
               w_vld_nxt = 1'b1;
               w_iss_nxt = 1'b0;
            end
         end
      endcase
   end

   always_comb begin
      w_lane = '0;
      for (int l = 0; l < 4; l++)
         w_lane[l] = lane_exp(w_s_nxt, w_g_nxt, 2'(l));
   end

   assign EXP0    = r_exp[0];
   assign EXP1    = r_exp[1];
   assign EXP2    = r_exp[2];
   assign EXP3    = r_exp[3];
   assign EXP_VLD = r_vld;
   assign TF_VLD  = r_tf_vld;
   assign STAGE   = r_s;
   assign GRP     = r_g;
   assign BUSY    = (r_state == S_RUN);
   assign DONE    = r_done;

endmodule

// File: tb/tb_tf_exp_gen.sv
// Scoreboard bench for tf_exp_gen: expected groups queued at START and
// popped on every EXP_VLD; handshake, stall and reset cases checked inline.
module tb_tf_exp_gen;

   logic       CLK, RSTn, START, HOLD;
   logic [7:0] EXP0, EXP1, EXP2, EXP3;
   logic       EXP_VLD, TF_VLD, BUSY, DONE;
   logic [2:0] STAGE;
   logic [4:0] GRP;

   int          n_cmp;
   int          n_bad;
   int          vld_cnt;
   time         t_start;
   logic [39:0] sb_q[$];

   tf_exp_gen #(.STAGES(8)) dut (
      .CLK(CLK), .RSTn(RSTn), .START(START), .HOLD(HOLD),
      .EXP0(EXP0), .EXP1(EXP1), .EXP2(EXP2), .EXP3(EXP3),
      .EXP_VLD(EXP_VLD), .TF_VLD(TF_VLD), .STAGE(STAGE), .GRP(GRP),
      .BUSY(BUSY), .DONE(DONE)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [39:0] got,
                        input logic [39:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Packed as {e3,e2,e1,e0,stage,grp}.
   function automatic logic [39:0] model(input int s, input int g);
      logic [39:0] r;
      int b, half, e;
      r = '0;
      for (int l = 0; l < 4; l++) begin
         b = 4 * g + l;
`ifdef TFGEN_DIT_EN
         half = 1 << s;
         e    = ((b % half) << (7 - s)) & 255;
`else
         half = 128 >> s;
         e    = ((b % half) << s) & 255;
`endif
         r[8 + 8*l +: 8] = e[7:0];
      end
      r[7:5] = s[2:0];
      r[4:0] = g[4:0];
      return r;
   endfunction

   function automatic logic [39:0] obs();
      return {EXP3, EXP2, EXP1, EXP0, STAGE, GRP};
   endfunction

   always @(negedge CLK) begin
      if (RSTn === 1'b1 && EXP_VLD === 1'b1) begin
         if (sb_q.size() == 0) check("sb_empty", 40'd1, 40'd0);
         else check("grp", obs(), sb_q.pop_front());
         vld_cnt++;
`ifdef TFGEN_DIT_EN
         if (STAGE == 3'd0)
            check("spot_s0", {8'd0, obs()[39:8]}, 40'd0);
         if (STAGE == 3'd7 && GRP == 5'd1)
            check("spot_s7g1", {8'd0, obs()[39:8]},
                  {8'd0, 8'd7, 8'd6, 8'd5, 8'd4});
`else
         if (STAGE == 3'd0 && GRP == 5'd0)
            check("spot_s0g0", {8'd0, obs()[39:8]},
                  {8'd0, 8'd3, 8'd2, 8'd1, 8'd0});
         if (STAGE == 3'd1 && GRP == 5'd17)
            check("spot_s1g17", {8'd0, obs()[39:8]},
                  {8'd0, 8'd14, 8'd12, 8'd10, 8'd8});
         if (STAGE == 3'd3 && GRP == 5'd5)
            check("spot_s3g5", {8'd0, obs()[39:8]},
                  {8'd0, 8'd56, 8'd48, 8'd40, 8'd32});
         if (STAGE == 3'd7 && GRP == 5'd20)
            check("spot_s7", {8'd0, obs()[39:8]}, 40'd0);
`endif
      end
   end

   // Caller is at a negedge; returns one negedge later.
   task automatic do_start(input logic h);
      START   = 1'b1;
      HOLD    = h;
      t_start = $time;
      vld_cnt = 0;
      for (int s = 0; s < 8; s++)
         for (int g = 0; g < 32; g++)
            sb_q.push_back(model(s, g));
      @(negedge CLK);
      START = 1'b0;
   endtask

   task automatic wait_done(input int want_cyc);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 600 && !seen; n++) begin
         @(negedge CLK);
         if (DONE === 1'b1) seen = 1'b1;
      end
      check("done_seen", 40'(seen), 40'd1);
      if (seen) begin
         check("done_cyc", 40'(int'(($time - t_start) / 10)), 40'(want_cyc));
         check("done_tf", 40'(TF_VLD), 40'd1);
         check("done_busy", 40'(BUSY), 40'd0);
         check("vld_cnt", 40'(vld_cnt), 40'd256);
         check("sb_left", 40'(sb_q.size()), 40'd0);
      end
   endtask

   task automatic find(input logic [2:0] s, input logic [4:0] g,
                       input bit any_g);
      bit found;
      found = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (EXP_VLD === 1'b1 && STAGE == s && (any_g || GRP == g)) begin
            found = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      check("find", 40'(found), 40'd1);
   endtask

   initial begin
      logic [39:0] frz;
      n_cmp   = 0;
      n_bad   = 0;
      vld_cnt = 0;
      t_start = 0;
      START   = 1'b0;
      HOLD    = 1'b0;
      RSTn    = 1'b1;
      #2 RSTn = 1'b0;
      #1;
      check("rst_data", obs(), 40'd0);
      check("rst_flags", 40'({EXP_VLD, TF_VLD, BUSY, DONE}), 40'd0);
      repeat (2) @(negedge CLK);
      RSTn = 1'b1;
      repeat (10) begin
         @(negedge CLK);
         check("idle", 40'({EXP_VLD, TF_VLD, BUSY}), 40'd0);
      end

      do_start(1'b0);
      wait_done(257);

      // Back-to-back START in the DONE cycle, with a 3-cycle stall.
      do_start(1'b0);
      find(3'd2, 5'd9, 1'b0);
      frz  = model(2, 9);
      HOLD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("hold_vld", 40'(EXP_VLD), 40'd0);
         check("hold_exp", obs(), frz);
         check("hold_tf", 40'(TF_VLD), 40'(i == 0));
      end
      HOLD = 1'b0;
      wait_done(260);

      do_start(1'b0);
      find(3'd4, 5'd0, 1'b1);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      wait_done(257);

      repeat (3) @(negedge CLK);
      do_start(1'b1);
      check("hs_busy", 40'({BUSY, EXP_VLD}), 40'b10);
      @(negedge CLK);
      check("hs_busy2", 40'({BUSY, EXP_VLD}), 40'b10);
      HOLD = 1'b0;
      wait_done(259);

      do_start(1'b0);
      find(3'd5, 5'd0, 1'b1);
      #2 RSTn = 1'b0;
      #1;
      sb_q.delete();
      check("mrst_data", obs(), 40'd0);
      check("mrst_flags", 40'({EXP_VLD, TF_VLD, BUSY, DONE}), 40'd0);
      @(negedge CLK);
      RSTn = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         check("mrst_idle", 40'({DONE, BUSY, EXP_VLD}), 40'd0);
      end
      do_start(1'b0);
      wait_done(257);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
